// File: rtl/calc_req_sequencer.sv
// rtl/calc_req_sequencer.sv - one-transaction request sequencer for a single calc1_top port
module calc_req_sequencer #(
  parameter int TIMEOUT = 10,
  parameter int TAGW    = 4
) (
  input  logic            c_clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_cmd,
  input  logic [31:0]     req_op1,
  input  logic [31:0]     req_op2,
  input  logic [TAGW-1:0] req_tag,
  output logic [3:0]      calc_cmd,
  output logic [31:0]     calc_data,
  input  logic [1:0]      calc_resp,
  input  logic [31:0]     calc_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [1:0]      rsp_resp,
  output logic [31:0]     rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_timeout,
  output logic            stray
);

  typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT, DONE} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t          state, state_n;
  logic [31:0]     op2_q, op2_n;
  logic [7:0]      cnt, cnt_n;
  logic            req_ready_n, rsp_valid_n, rsp_timeout_n, stray_n;
  logic [3:0]      calc_cmd_n;
  logic [31:0]     calc_data_n, rsp_data_n;
  logic [1:0]      rsp_resp_n;
  logic [TAGW-1:0] rsp_tag_n;

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op2_q       <= '0;
      cnt         <= '0;
      req_ready   <= 1'b0;
      calc_cmd    <= '0;
      calc_data   <= '0;
      rsp_valid   <= 1'b0;
      rsp_resp    <= '0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_timeout <= 1'b0;
      stray       <= 1'b0;
    end else begin
      state       <= state_n;
      op2_q       <= op2_n;
      cnt         <= cnt_n;
      req_ready   <= req_ready_n;
      calc_cmd    <= calc_cmd_n;
      calc_data   <= calc_data_n;
      rsp_valid   <= rsp_valid_n;
      rsp_resp    <= rsp_resp_n;
      rsp_data    <= rsp_data_n;
      rsp_tag     <= rsp_tag_n;
      rsp_timeout <= rsp_timeout_n;
      stray       <= stray_n;
    end
  end

  always_comb begin
    state_n       = state;
    op2_n         = op2_q;
    cnt_n         = cnt;
    calc_cmd_n    = calc_cmd;
    calc_data_n   = calc_data;
    rsp_valid_n   = rsp_valid;
    rsp_resp_n    = rsp_resp;
    rsp_data_n    = rsp_data;
    rsp_tag_n     = rsp_tag;
    rsp_timeout_n = rsp_timeout;
    stray_n       = stray;
    case (state)
      IDLE: begin
        if (calc_resp != 2'd0) stray_n = 1'b1;
        if (req_valid && req_ready) begin
          op2_n     = req_op2;
          rsp_tag_n = req_tag;
          if (req_cmd != 4'd0) begin
            calc_cmd_n  = req_cmd;
            calc_data_n = req_op1;
            state_n     = SEND1;
          end else begin
            rsp_resp_n    = 2'd0;
            rsp_data_n    = '0;
            rsp_timeout_n = 1'b0;
            state_n       = DONE;
          end
        end
      end
      SEND1: begin
        if (calc_resp != 2'd0) stray_n = 1'b1;
        calc_cmd_n  = 4'd0;
        calc_data_n = op2_q;
        cnt_n       = 8'd0;
        state_n     = SEND2;
      end
      SEND2, WAIT: begin
        calc_data_n = '0;
        if (calc_resp != 2'd0) begin
          rsp_resp_n    = calc_resp;
          rsp_data_n    = calc_rdata;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          state_n       = DONE;
        end else if (cnt == LAST) begin
          rsp_resp_n    = 2'd0;
          rsp_data_n    = '0;
          rsp_timeout_n = 1'b1;
          rsp_valid_n   = 1'b1;
          state_n       = DONE;
        end else begin
          cnt_n   = cnt + 8'd1;
          state_n = WAIT;
        end
      end
      DONE: begin
        // A no-op enters DONE with rsp_valid low; it rises one edge later.
        if (calc_resp != 2'd0) stray_n = 1'b1;
        if (rsp_valid && rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end else begin
          rsp_valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    req_ready_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_calc_req_sequencer.sv
// tb/tb_calc_req_sequencer.sv - directed and randomized bench for calc_req_sequencer
module tb_calc_req_sequencer;
  localparam int TIMEOUT = 10;
  localparam int TAGW    = 4;

  logic            c_clk, reset_n;
  logic            req_valid, req_ready;
  logic [3:0]      req_cmd, calc_cmd;
  logic [31:0]     req_op1, req_op2, calc_data, calc_rdata, rsp_data;
  logic [TAGW-1:0] req_tag, rsp_tag;
  logic [1:0]      calc_resp, rsp_resp;
  logic            rsp_valid, rsp_ready, rsp_timeout, stray;

  int   checks = 0;
  int   failures = 0;
  logic stray_exp = 1'b0;

  calc_req_sequencer #(.TIMEOUT(TIMEOUT), .TAGW(TAGW)) dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .calc_cmd(calc_cmd), .calc_data(calc_data),
    .calc_resp(calc_resp), .calc_rdata(calc_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .stray(stray)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_calc_cmd"}, calc_cmd, 0);
    chk({tag, "_calc_data"}, calc_data, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_tag"}, rsp_tag, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_stray"}, stray, 0);
  endtask

  // k: WAIT sample index at which the port answers (-1 = silent); hold: rsp_ready low cycles
  task automatic run_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [TAGW-1:0] tag, input int k, input logic [1:0] code,
                         input logic [31:0] rdata, input int hold);
    int          v, n;
    logic [1:0]  er;
    logic [31:0] ed, exp_data;
    logic        et;
    logic [3:0]  exp_cmd;
    if (cmd == 4'd0) begin
      v = 1; er = 2'd0; ed = 0; et = 1'b0;
    end else if (k >= 0 && k < TIMEOUT && code != 2'd0) begin
      v = 2 + k; er = code; ed = rdata; et = 1'b0;
    end else begin
      v = 1 + TIMEOUT; er = 2'd0; ed = 0; et = 1'b1;
    end
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge c_clk);
      n++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_cmd = cmd; req_op1 = op1; req_op2 = op2; req_tag = tag;
    @(negedge c_clk);
    req_valid = 1'b0; req_cmd = 4'($urandom); req_op1 = $urandom; req_op2 = $urandom;
    req_tag = TAGW'($urandom);
    for (int i = 0; i <= v; i++) begin
      if (cmd != 4'd0 && k >= 0 && i == 1 + k) begin
        calc_resp = code; calc_rdata = rdata;
      end else begin
        calc_resp = 2'd0; calc_rdata = $urandom;
      end
      exp_cmd  = (cmd != 4'd0 && i == 0) ? cmd : 4'd0;
      exp_data = (cmd == 4'd0) ? 32'd0 : (i == 0) ? op1 : (i == 1) ? op2 : 32'd0;
      chk("calc_cmd", calc_cmd, exp_cmd);
      chk("calc_data", calc_data, exp_data);
      chk("rsp_valid_timing", rsp_valid, (i >= v));
      chk("req_ready_busy", req_ready, 0);
      if (i < v) @(negedge c_clk);
    end
    calc_resp = 2'd0;
    chk("rsp_resp", rsp_resp, er);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_tag", rsp_tag, tag);
    chk("rsp_timeout", rsp_timeout, et);
    chk("stray_txn", stray, stray_exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge c_clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_resp", rsp_resp, er);
      chk("hold_rsp_data", rsp_data, ed);
      chk("hold_rsp_tag", rsp_tag, tag);
      chk("hold_rsp_timeout", rsp_timeout, et);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge c_clk);
    rsp_ready = 1'b0;
    chk("after_hs_rsp_valid", rsp_valid, 0);
    chk("after_hs_req_ready", req_ready, 1);
  endtask

  initial begin
    int          k;
    logic [3:0]  cmd;
    reset_n = 1'b1; req_valid = 1'b0; req_cmd = 0; req_op1 = 0; req_op2 = 0; req_tag = 0;
    calc_resp = 2'd0; calc_rdata = 0; rsp_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge c_clk);
    reset_n = 1'b1;
    @(negedge c_clk);
    chk("reset_release_req_ready", req_ready, 1);

    run_txn(4'd1, 32'h64, 32'h27, 4'd5, 3, 2'd1, 32'h8B, 0);
    run_txn(4'd1, 32'h5, 32'h1, 4'd9, -1, 2'd0, 32'h0, 0);
    run_txn(4'd0, 32'h1234, 32'h5678, 4'd3, 0, 2'd1, 32'hABCD, 0);
    run_txn(4'd1, 32'hFFFF_FFFF, 32'h1, 4'd12, 2, 2'd2, 32'hDEAD_0001, 5);
    run_txn(4'd3, 32'h7, 32'h0, 4'd1, 0, 2'd3, 32'hC0DE_0003, 1);
    run_txn(4'd2, 32'h9, 32'h4, 4'd2, TIMEOUT - 1, 2'd1, 32'h5, 0);

    for (int t = 0; t < 20; t++) begin
      cmd = 4'($urandom_range(0, 15));
      k   = int'($urandom_range(0, TIMEOUT));
      if (k == TIMEOUT) k = -1;
      run_txn(cmd, $urandom, $urandom, TAGW'($urandom), k, 2'($urandom_range(1, 3)),
              $urandom, int'($urandom_range(0, 3)));
    end

    @(negedge c_clk);
    calc_resp = 2'd1;
    @(negedge c_clk);
    calc_resp = 2'd0;
    stray_exp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("stray_sticky", stray, 1);
      chk("stray_no_rsp_valid", rsp_valid, 0);
      @(negedge c_clk);
    end

    req_valid = 1'b1; req_cmd = 4'd2; req_op1 = 32'h11; req_op2 = 32'h22; req_tag = 4'd6;
    @(negedge c_clk);
    req_valid = 1'b0;
    repeat (3) @(negedge c_clk);
    reset_n = 1'b0;
    stray_exp = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge c_clk);
    reset_n = 1'b1;
    #1 chk("release_req_ready_low", req_ready, 0);
    @(negedge c_clk);
    chk("release_req_ready_high", req_ready, 1);
    calc_resp = 2'd2;
    @(negedge c_clk);
    calc_resp = 2'd0;
    stray_exp = 1'b1;
    chk("late_resp_stray", stray, 1);
    chk("late_resp_no_valid", rsp_valid, 0);
    @(negedge c_clk);
    chk("late_resp_no_valid2", rsp_valid, 0);
    chk("late_resp_stray2", stray, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
